// File: rtl/udp_tx_arb_pkg.sv
// Shared types and sizing for the UDP transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udp_arb_pkg;

    localparam int UDP_ARB_MAX_N = 8;
    localparam int UDP_ARB_GW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } udp_arb_state_t;

endpackage

// File: rtl/udp_tx_arb_if.sv
// Bundle of per-source request/payload lanes and the single stack-side port.
// Latency: n/a (wiring only).
// Backpressure: header and payload use valid/ready on both sides.
interface udp_tx_arb_if #(
    parameter int N  = 2,
    parameter int LW = 16
);

    logic [N-1:0]    s_hdr_valid;
    logic [N-1:0]    s_hdr_ready;
    logic [LW*N-1:0] s_length;
    logic [8*N-1:0]  s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;

    logic            m_hdr_valid;
    logic            m_hdr_ready;
    logic [LW-1:0]   m_length;
    logic [7:0]      m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;

    // Environment side: packet sources plus the transmit stack.
    modport master (
        output s_hdr_valid, s_length, s_tdata, s_tvalid, s_tlast,
        output m_hdr_ready, m_tready,
        input  s_hdr_ready, s_tready,
        input  m_hdr_valid, m_length, m_tdata, m_tvalid, m_tlast
    );

    // Arbiter side.
    modport slave (
        input  s_hdr_valid, s_length, s_tdata, s_tvalid, s_tlast,
        input  m_hdr_ready, m_tready,
        output s_hdr_ready, s_tready,
        output m_hdr_valid, m_length, m_tdata, m_tvalid, m_tlast
    );

endinterface

// File: rtl/udp_tx_arb_rr_pick.sv
// Round-robin picker: first requester found searching upward from last+1 mod N.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the winner.
module rr_pick
    import udp_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]            req,
    input  logic [UDP_ARB_GW-1:0]   last,
    output logic [N-1:0]            win,
    output logic [UDP_ARB_GW-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        win = '0;
        idx = '0;
        for (int off = N; off >= 1; off--) begin
            for (int i = 0; i < N; i++) begin
                if (i == (int'(last) + off) % N && req[i]) begin
                    win    = '0;
                    win[i] = 1'b1;
                    idx    = UDP_ARB_GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// Packet-granular arbiter of N sources onto one UDP tx port; UDP_ARB_PRIO0_EN gives source 0 strict priority.
// Latency: grant registered 1 cycle after request; header/payload muxes are combinational, 1 IDLE cycle per frame.
// Backpressure: m_hdr_ready/m_tready pass straight to the granted source only; others see ready low.
module udp_tx_arb
    import udp_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    udp_tx_arb_if.slave           bus,
    output logic [UDP_ARB_GW-1:0] grant,
    output logic                  busy,
    output logic [16*N-1:0]       pkt_cnt
);

    udp_arb_state_t        state, state_nxt;
    logic [UDP_ARB_GW-1:0] last, grant_nxt, pick_idx;
    logic [N-1:0]          pick_req, pick_win;
    logic [15:0]           cnt [N];

    logic                  sel_hvld, sel_tvld, sel_tlast, pay_done;
    logic [LW-1:0]         sel_len;
    logic [7:0]            sel_tdata;

`ifdef UDP_ARB_PRIO0_EN
    // Source 0 is handled by the override below; the rest rotate among themselves.
    assign pick_req = {bus.s_hdr_valid[N-1:1], 1'b0};
`else
    assign pick_req = bus.s_hdr_valid;
`endif

    rr_pick #(.N(N)) u_pick (
        .req  (pick_req),
        .last (last),
        .win  (pick_win),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_hvld  = 1'b0;
        sel_len   = '0;
        sel_tvld  = 1'b0;
        sel_tdata = '0;
        sel_tlast = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == UDP_ARB_GW'(i)) begin
                sel_hvld  = bus.s_hdr_valid[i];
                sel_len   = bus.s_length[LW*i +: LW];
                sel_tvld  = bus.s_tvalid[i];
                sel_tdata = bus.s_tdata[8*i +: 8];
                sel_tlast = bus.s_tlast[i];
            end
        end
    end

    assign pay_done = (state == PAY) && sel_tvld && bus.m_tready && sel_tlast;

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        bus.m_hdr_valid = 1'b0;
        bus.m_length    = '0;
        bus.m_tvalid    = 1'b0;
        bus.m_tdata     = '0;
        bus.m_tlast     = 1'b0;
        bus.s_hdr_ready = '0;
        bus.s_tready    = '0;
        case (state)
            IDLE: begin
`ifdef UDP_ARB_PRIO0_EN
                if (bus.s_hdr_valid[0]) begin
                    grant_nxt = '0;
                    state_nxt = HDR;
                end else
`endif
                if (|pick_win) begin
                    grant_nxt = pick_idx;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                bus.m_hdr_valid = sel_hvld;
                bus.m_length    = sel_len;
                for (int i = 0; i < N; i++) begin
                    bus.s_hdr_ready[i] = (grant == UDP_ARB_GW'(i)) && bus.m_hdr_ready;
                end
                // A withdrawn request abandons the grant without touching last.
                if (!sel_hvld) begin
                    state_nxt = IDLE;
                end else if (bus.m_hdr_ready) begin
                    state_nxt = PAY;
                end
            end
            PAY: begin
                bus.m_tvalid = sel_tvld;
                bus.m_tdata  = sel_tdata;
                bus.m_tlast  = sel_tlast;
                for (int i = 0; i < N; i++) begin
                    bus.s_tready[i] = (grant == UDP_ARB_GW'(i)) && bus.m_tready;
                end
                if (pay_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= UDP_ARB_GW'(N - 1);
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            busy  <= (state_nxt != IDLE);
            if (pay_done) begin
                last <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else if (pay_done) begin
            for (int i = 0; i < N; i++) begin
                if (grant == UDP_ARB_GW'(i)) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        assign pkt_cnt[16*g +: 16] = cnt[g];
    end

endmodule
